fetch_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It owns the PC-write enable, PC-source select, IF/ID hold, and per-stage flush signals driven into instruction fetch and the pipeline registers. It arbitrates between EX-resolved branches (beq/bne), ID-decoded jumps, load-use stalls and an external halt/resume request. The fetch stage and pipeline registers obey its outputs, so the software no longer needs NOP padding for hazards.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_hazard_ctrl_if.sv | 40 ++++
 rtl/load_use_detect.sv | 14 +
 rtl/fetch_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fetch_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch/hazard sequencing controller.
package fetch_ctrl_pkg;

  // Controller states, visible on state_o.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STALL    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  // PC source select values driven into instruction fetch.
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;

  // Instruction word loaded into a flushed pipeline register (add $0,$0,$0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Pipeline-side hazard inputs and fetch/pipeline-register control outputs.
interface fetch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             halt_req;
  logic             resume;

  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirects;

  // Controller side: observes the pipeline, drives the enables/flushes.
  modport master (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_regwrite,
           ex_rd, ex_branch_taken, halt_req, resume,
    output pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, state_o,
           stall_cycles, redirects
  );

  // Pipeline side: presents hazard information, obeys the controls.
  modport slave (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_regwrite,
           ex_rd, ex_branch_taken, halt_req, resume,
    input  pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, state_o,
           stall_cycles, redirects
  );
endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a lw in EX whose destination feeds the ID instruction.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_rd,
  output logic       hazard
);
  // $0 is hard-wired, so a load targeting it never creates a dependency.
  assign hazard = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Pipeline sequencing controller: PC enable/select, IF/ID hold, stage flushes,
// arbitrating branches, jumps, load-use stalls and halt/resume.
module fetch_hazard_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int IMEM_LAT   = 1,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  fetch_hazard_ctrl_if.master bus
);
  localparam logic [2:0] REDIR_INIT = 3'(IMEM_LAT - 1);
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             halt_pending_q, halt_pending_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirects_q, redirects_d;

  logic       hazard;
  logic       redirect_inc;
  logic       pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0] pc_sel;

  load_use_detect u_load_use_detect (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .ex_memread (bus.ex_memread),
    .ex_regwrite(bus.ex_regwrite),
    .ex_rd      (bus.ex_rd),
    .hazard     (hazard)
  );

  // Next-state, countdown and control decode from current state and inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    halt_pending_d = halt_pending_q;
    pc_write       = 1'b1;
    pc_sel         = PC_SEL_SEQ;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    redirect_inc   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          pc_sel       = PC_SEL_BR;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          state_d      = ST_REDIRECT;
          cnt_d        = REDIR_INIT;
          redirect_inc = 1'b1;
        end else if (bus.id_jump) begin
          pc_sel       = PC_SEL_JMP;
          ifid_flush   = 1'b1;
          state_d      = ST_REDIRECT;
          cnt_d        = REDIR_INIT;
          redirect_inc = 1'b1;
        end else if (hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          state_d    = (LOAD_STALL == 1) ? ST_RUN : ST_STALL;
          cnt_d      = STALL_INIT;
        end else if (bus.halt_req || halt_pending_q) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          idex_flush     = 1'b1;
          state_d        = ST_HALT;
          halt_pending_d = 1'b0;
        end
      end

      // The RUN cycle that detected the hazard is the first bubble, so STALL
      // covers the remaining LOAD_STALL-1 bubbles and exits as cnt reaches 0.
      ST_STALL: begin
        if (bus.halt_req) halt_pending_d = 1'b1;
        if (bus.ex_branch_taken) begin
          pc_sel       = PC_SEL_BR;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          state_d      = ST_REDIRECT;
          cnt_d        = REDIR_INIT;
          redirect_inc = 1'b1;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      // ID contents are stale here; only a new taken branch matters.
      ST_REDIRECT: begin
        if (bus.halt_req) halt_pending_d = 1'b1;
        ifid_flush = 1'b1;
        if (bus.ex_branch_taken) begin
          pc_sel       = PC_SEL_BR;
          idex_flush   = 1'b1;
          cnt_d        = REDIR_INIT;
          redirect_inc = 1'b1;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_HALT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        if (bus.resume) state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (!pc_write && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
    redirects_d = redirects_q;
    if (redirect_inc && !(&redirects_q)) redirects_d = redirects_q + 1'b1;
  end

  // Reset overrides the controls immediately so the pipeline is frozen and
  // flushed for as long as rst is held, independent of the clock.
  always_comb begin
    if (rst) begin
      bus.pc_write   = 1'b0;
      bus.pc_sel     = PC_SEL_SEQ;
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else begin
      bus.pc_write   = pc_write;
      bus.pc_sel     = pc_sel;
      bus.ifid_write = ifid_write;
      bus.ifid_flush = ifid_flush;
      bus.idex_flush = idex_flush;
    end
  end

  assign bus.state_o      = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.redirects    = redirects_q;

  // State, countdown, pending halt and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= 3'd0;
      halt_pending_q <= 1'b0;
      stall_cycles_q <= '0;
      redirects_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      halt_pending_q <= halt_pending_d;
      stall_cycles_q <= stall_cycles_d;
      redirects_q    <= redirects_d;
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl: stimulus pushes expected responses
// from a bubble/flush-count model; a negedge monitor pops and compares.
module tb_fetch_hazard_ctrl;
  localparam int IMEM_LAT   = 2;
  localparam int LOAD_STALL = 3;
  localparam int CNT_W      = 6;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fetch_hazard_ctrl #(
    .IMEM_LAT  (IMEM_LAT),
    .LOAD_STALL(LOAD_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_jump;
    logic       ex_memread;
    logic       ex_regwrite;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       halt_req;
    logic       resume;
  } stim_t;

  typedef struct packed {
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirects;
  } resp_t;

  typedef struct {
    resp_t r;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "reset";

  // Behavioural model: remaining bubbles, remaining stale-fetch cycles,
  // halted flag, deferred halt, and the two counts as plain integers.
  int m_stall_left = 0;
  int m_redir_left = 0;
  bit m_halted     = 1'b0;
  bit m_pend       = 1'b0;
  int m_stalls     = 0;
  int m_redirs     = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic check(input string tag, input resp_t got, input resp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got pw=%b sel=%0d iw=%b iff=%b idf=%b st=%0d sc=%0d rd=%0d want pw=%b sel=%0d iw=%b iff=%b idf=%b st=%0d sc=%0d rd=%0d",
               tag, $time, got.pc_write, got.pc_sel, got.ifid_write, got.ifid_flush,
               got.idex_flush, got.state, got.stall_cycles, got.redirects,
               want.pc_write, want.pc_sel, want.ifid_write, want.ifid_flush,
               want.idex_flush, want.state, want.stall_cycles, want.redirects);
    end
  endtask

  // Drive one cycle of stimulus and push the model's expected response.
  task automatic apply(input stim_t s);
    resp_t e;
    bit    hz;
    bit    br_out;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    bus.id_rs           = s.id_rs;
    bus.id_rt           = s.id_rt;
    bus.id_uses_rt      = s.id_uses_rt;
    bus.id_jump         = s.id_jump;
    bus.ex_memread      = s.ex_memread;
    bus.ex_regwrite     = s.ex_regwrite;
    bus.ex_rd           = s.ex_rd;
    bus.ex_branch_taken = s.ex_branch_taken;
    bus.halt_req        = s.halt_req;
    bus.resume          = s.resume;

    if (s.rst) begin
      m_stall_left = 0; m_redir_left = 0; m_halted = 0; m_pend = 0;
      m_stalls = 0; m_redirs = 0;
      e = '0;
      e.ifid_flush = 1'b1;
      e.idex_flush = 1'b1;
    end else begin
      hz = s.ex_memread && s.ex_regwrite && (s.ex_rd != 0) &&
           ((s.ex_rd == s.id_rs) || (s.id_uses_rt && (s.ex_rd == s.id_rt)));
      e.state = m_halted ? 2'd3 : (m_redir_left > 0) ? 2'd2 :
                (m_stall_left > 0) ? 2'd1 : 2'd0;
      e.stall_cycles = CNT_W'(m_stalls);
      e.redirects    = CNT_W'(m_redirs);
      e.pc_write = 1; e.pc_sel = 0; e.ifid_write = 1;
      e.ifid_flush = 0; e.idex_flush = 0;
      br_out = 0;

      if (m_halted) begin
        e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
        if (s.resume) m_halted = 0;
      end else if (m_redir_left > 0) begin
        if (s.halt_req) m_pend = 1;
        e.ifid_flush = 1;
        if (s.ex_branch_taken) br_out = 1;
        else m_redir_left--;
      end else if (m_stall_left > 0) begin
        if (s.halt_req) m_pend = 1;
        if (s.ex_branch_taken) begin
          br_out = 1;
          m_stall_left = 0;
        end else begin
          e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
          m_stall_left--;
        end
      end else begin
        if (s.ex_branch_taken) begin
          br_out = 1;
        end else if (s.id_jump) begin
          e.pc_sel = 2; e.ifid_flush = 1;
          m_redir_left = IMEM_LAT;
          m_redirs = (m_redirs < CMAX) ? m_redirs + 1 : CMAX;
        end else if (hz) begin
          e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
          m_stall_left = LOAD_STALL - 1;
        end else if (s.halt_req || m_pend) begin
          e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
          m_halted = 1;
          m_pend = 0;
        end
      end

      if (br_out) begin
        e.pc_sel = 1; e.ifid_flush = 1; e.idex_flush = 1;
        m_redir_left = IMEM_LAT;
        m_redirs = (m_redirs < CMAX) ? m_redirs + 1 : CMAX;
      end
      if (!e.pc_write) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
    end
    exp_q.push_back('{r: e, tag: phase});
  endtask

  task automatic apply_n(input stim_t s, input int n);
    for (int i = 0; i < n; i++) apply(s);
  endtask

  // Monitor: the controller presents a response every cycle; compare mid-cycle.
  initial begin
    exp_t  x;
    resp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a.pc_write     = bus.pc_write;
        a.pc_sel       = bus.pc_sel;
        a.ifid_write   = bus.ifid_write;
        a.ifid_flush   = bus.ifid_flush;
        a.idex_flush   = bus.idex_flush;
        a.state        = bus.state_o;
        a.stall_cycles = bus.stall_cycles;
        a.redirects    = bus.redirects;
        check(x.tag, a, x.r);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.id_jump = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = '0;
    bus.ex_branch_taken = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;

    // Reset state and first run cycles.
    s = idle(); s.rst = 1'b1;
    apply_n(s, 3);
    phase = "run_idle";
    apply_n(idle(), 2);

    // lw $3 in EX, ID add reads rs=$3.
    phase = "load_use";
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd3; s.id_rs = 5'd3;
    apply(s);
    apply_n(idle(), 4);
    // Same dependency through rt.
    phase = "load_use_rt";
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd7;
    s.id_rt = 5'd7; s.id_uses_rt = 1; s.id_rs = 5'd1;
    apply(s);
    apply_n(idle(), 3);
    // A load to $0 never stalls.
    phase = "load_rd0";
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd0;
    s.id_rs = 5'd0; s.id_rt = 5'd0; s.id_uses_rt = 1;
    apply(s);
    apply_n(idle(), 2);

    // Branch aborting a stall on its second stall-state cycle.
    phase = "stall_abort";
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd4; s.id_rs = 5'd4;
    apply(s);
    apply(idle());
    s = idle(); s.ex_branch_taken = 1;
    apply(s);
    apply_n(idle(), 3);

    // Jump and branch together: branch wins.
    phase = "br_vs_jmp";
    s = idle(); s.ex_branch_taken = 1; s.id_jump = 1;
    apply(s);
    s = idle(); s.id_jump = 1;
    apply_n(s, 2);
    apply_n(idle(), 2);

    // Reset arriving in the middle of a stall.
    phase = "reset_mid_stall";
    s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd9; s.id_rs = 5'd9;
    apply(s);
    apply(idle());
    s = idle(); s.rst = 1;
    apply_n(s, 2);
    apply_n(idle(), 2);

    // Halt requested during a redirect, taken on the first clean RUN cycle.
    phase = "halt_in_redirect";
    s = idle(); s.ex_branch_taken = 1;
    apply(s);
    s = idle(); s.halt_req = 1;
    apply(s);
    apply(idle());
    apply(idle());
    apply_n(idle(), 10);
    s = idle(); s.resume = 1;
    apply(s);
    apply_n(idle(), 2);

    // Long halt drives stall_cycles into saturation.
    phase = "saturate";
    s = idle(); s.halt_req = 1;
    apply(s);
    apply_n(idle(), CMAX + 5);
    s = idle(); s.resume = 1;
    apply(s);
    apply_n(idle(), 2);

    // Randomized traffic with a small register space to provoke hazards.
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst             = ($urandom_range(0, 299) == 0);
      s.id_rs           = 5'($urandom_range(0, 3));
      s.id_rt           = 5'($urandom_range(0, 3));
      s.id_uses_rt      = 1'($urandom_range(0, 1));
      s.ex_rd           = 5'($urandom_range(0, 3));
      s.ex_memread      = ($urandom_range(0, 9) < 4);
      s.ex_regwrite     = ($urandom_range(0, 9) < 7);
      s.ex_branch_taken = ($urandom_range(0, 99) < 12);
      s.id_jump         = ($urandom_range(0, 99) < 12);
      s.halt_req        = ($urandom_range(0, 99) < 4);
      s.resume          = ($urandom_range(0, 5) == 0);
      apply(s);
    end
    apply_n(idle(), 2);

    // Every pushed expectation must have been consumed by the monitor.
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
